// File: rtl/fir_stream_sequencer.sv
// Buffers source samples in a small FIFO, drives them one at a time into the FIR core's
// level/edge handshake, and returns each result on a valid/ready stream tagged with a frame-last flag.
module fir_stream_sequencer #(
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 38,
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_LEN  = 15000,
  parameter int TIMEOUT    = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [IN_WIDTH-1:0]  fir_in,
  output logic                 fir_in_valid,
  input  logic [OUT_WIDTH-1:0] fir_out,
  input  logic                 fir_out_valid,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int FW = $clog2(FRAME_LEN + 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT);
  localparam logic [FW-1:0] FRAME_END  = FW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t              state;
  logic [IN_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;
  logic [TW-1:0]       timer;
  logic [FW-1:0]       frame_cnt;
  logic                prev_fov;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic rise;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  // A sample only leaves the FIFO when the single output register is free.
  assign pop      = (state == IDLE) && !empty && !out_valid;
  assign rise     = fir_out_valid && !prev_fov;
  assign busy     = !empty || (state != IDLE) || out_valid;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      timer        <= '0;
      frame_cnt    <= '0;
      prev_fov     <= 1'b0;
      fir_in       <= '0;
      fir_in_valid <= 1'b0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      prev_fov <= fir_out_valid;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: ;
      endcase

      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            fir_in       <= mem[rd_ptr];
            fir_in_valid <= 1'b1;
            timer        <= '0;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= timer + TW'(1);
          // A result arriving on the final timer cycle still wins over the timeout.
          if (rise) begin
            out_data     <= fir_out;
            out_valid    <= 1'b1;
            out_last     <= (frame_cnt == FRAME_END);
            frame_cnt    <= (frame_cnt == FRAME_END) ? '0 : frame_cnt + FW'(1);
            fir_in_valid <= 1'b0;
            state        <= GAP;
          end else if (timer == TIMER_MAX) begin
            fir_in_valid <= 1'b0;
            err_timeout  <= 1'b1;
            state        <= GAP;
          end
        end
        GAP: begin
          if (!fir_out_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_stream_sequencer.sv
// Directed bench for fir_stream_sequencer: a behavioural FIR (result = 5*sample, 3 cycles) plus a
// queue-based scoreboard checked every negedge, and hand-computed literal checks per scenario.
module tb_fir_stream_sequencer;

  localparam int IN_W  = 16;
  localparam int OUT_W = 38;
  localparam int DEPTH = 4;
  localparam int FLEN  = 3;
  localparam int TMO   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [IN_W-1:0]  fir_in;
  logic             fir_in_valid;
  logic [OUT_W-1:0] fir_out;
  logic             fir_out_valid;
  logic             busy;
  logic             err_timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fir_stream_sequencer #(
    .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .FIFO_DEPTH(DEPTH), .FRAME_LEN(FLEN), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .fir_in(fir_in), .fir_in_valid(fir_in_valid), .fir_out(fir_out), .fir_out_valid(fir_out_valid),
    .busy(busy), .err_timeout(err_timeout)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural FIR: answers 3 cycles into a request, holds output_valid until input_valid drops.
  logic fir_enable;
  int   fir_hi;
  initial begin
    fir_out = '0;
    fir_out_valid = 1'b0;
    fir_hi = 0;
    forever begin
      @(posedge clk);
      #1;
      if (fir_in_valid && fir_enable) begin
        fir_hi++;
        if (fir_hi >= 3) begin
          fir_out_valid = 1'b1;
          fir_out = OUT_W'(fir_in) * OUT_W'(5);
        end
      end else begin
        fir_hi = 0;
        fir_out_valid = 1'b0;
      end
    end
  end

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             last;
  } res_t;

  logic [IN_W-1:0] exp_fifo[$];
  res_t            exp_res[$];
  logic [IN_W-1:0] inflight;
  bit              responded;
  bit              prev_fiv;
  bit              prev_ov;
  bit              exp_err;
  int              hi_len;
  int              rcount;

  // Scoreboard: everything observed at negedge, where the values are those the next edge samples.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_fifo.delete();
        exp_res.delete();
        prev_fiv = 0;
        prev_ov = 0;
        exp_err = 0;
        hi_len = 0;
        rcount = 0;
        responded = 0;
      end else begin
        if (fir_in_valid && !prev_fiv) begin
          check_output("issue_while_out_valid", 64'(prev_ov), 64'(0));
          check_output("issue_has_sample", 64'(exp_fifo.size() != 0), 64'(1));
          if (exp_fifo.size() != 0) inflight = exp_fifo.pop_front();
          responded = 0;
          hi_len = 0;
          check_output("issue_fir_in", 64'(fir_in), 64'(inflight));
        end
        if (fir_in_valid) begin
          hi_len++;
          check_output("fir_in_stable", 64'(fir_in), 64'(inflight));
          check_output("fir_in_valid_len", 64'(hi_len <= TMO + 1), 64'(1));
          if (fir_out_valid) responded = 1;
        end
        if (!fir_in_valid && prev_fiv) begin
          if (responded) begin
            res_t r;
            rcount++;
            r.data = OUT_W'(inflight) * OUT_W'(5);
            r.last = (rcount % FLEN) == 0;
            exp_res.push_back(r);
          end else begin
            check_output("timeout_len", 64'(hi_len), 64'(TMO + 1));
            exp_err = 1;
          end
        end
        check_output("in_ready", 64'(in_ready), 64'(exp_fifo.size() < DEPTH));
        check_output("err_timeout", 64'(err_timeout), 64'(exp_err));
        check_output("out_valid", 64'(out_valid), 64'(exp_res.size() != 0));
        if (out_valid && exp_res.size() != 0) begin
          check_output("out_data", 64'(out_data), 64'(exp_res[0].data));
          check_output("out_last", 64'(out_last), 64'(exp_res[0].last));
          if (out_ready) void'(exp_res.pop_front());
        end
        if (in_valid && in_ready) exp_fifo.push_back(in_data);
        prev_fiv = fir_in_valid;
        prev_ov = out_valid;
      end
    end
  end

  // Records out_last of each transferred result since the last reset.
  int          nres;
  logic [15:0] lastv;
  initial begin
    nres = 0;
    lastv = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        nres = 0;
        lastv = '0;
      end else if (out_valid && out_ready) begin
        if (nres < 16) lastv[nres[3:0]] = out_last;
        nres++;
      end
    end
  end

  bit stall_seen;

  task automatic push_sample(input logic [IN_W-1:0] d);
    in_valid = 1'b1;
    in_data = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) break;
      stall_seen = 1'b1;
    end
    check_output("push_accepted", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) break;
    end
    check_output("wait_out_valid", 64'(out_valid), 64'(1));
  endtask

  task automatic wait_fir_in_valid();
    for (int i = 0; i < 100; i++) begin
      if (fir_in_valid) break;
      @(posedge clk);
      #1;
    end
    check_output("wait_fir_in_valid", 64'(fir_in_valid), 64'(1));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
    end
    check_output("wait_idle", 64'(busy), 64'(0));
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bit fiv_seen;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    fir_enable = 1'b1;
    stall_seen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_in_ready", 64'(in_ready), 64'(1));
    check_output("rst_out_valid", 64'(out_valid), 64'(0));
    check_output("rst_out_last", 64'(out_last), 64'(0));
    check_output("rst_out_data", 64'(out_data), 64'(0));
    check_output("rst_fir_in", 64'(fir_in), 64'(0));
    check_output("rst_fir_in_valid", 64'(fir_in_valid), 64'(0));
    check_output("rst_busy", 64'(busy), 64'(0));
    check_output("rst_err_timeout", 64'(err_timeout), 64'(0));

    $display("[TB] single sample");
    rst = 1'b0;
    push_sample(16'h0005);
    @(posedge clk);
    #1;
    check_output("t1_fir_in_valid", 64'(fir_in_valid), 64'(1));
    check_output("t1_fir_in", 64'(fir_in), 64'(16'h0005));
    wait_out_valid(n);
    check_output("t1_latency", 64'(n), 64'(3));
    check_output("t1_out_data", 64'(out_data), 64'(38'h19));
    check_output("t1_out_last", 64'(out_last), 64'(0));

    $display("[TB] backpressure");
    push_sample(16'h0007);
    fiv_seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (fir_in_valid) fiv_seen = 1;
    end
    check_output("t3_no_issue", 64'(fiv_seen), 64'(0));
    check_output("t3_out_data_held", 64'(out_data), 64'(38'h19));
    check_output("t3_out_valid_held", 64'(out_valid), 64'(1));
    check_output("t3_busy", 64'(busy), 64'(1));
    out_ready = 1'b1;
    wait_out_valid(n);
    check_output("t3_second_result", 64'(out_data), 64'(38'h23));
    wait_idle();

    $display("[TB] burst");
    stall_seen = 1'b0;
    for (int i = 1; i <= 6; i++) push_sample(IN_W'(i));
    check_output("t2_in_ready_dropped", 64'(stall_seen), 64'(1));
    wait_idle();

    $display("[TB] timeout");
    fir_enable = 1'b0;
    push_sample(16'h0009);
    wait_fir_in_valid();
    n = 1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (!fir_in_valid) break;
      n++;
    end
    check_output("t5_high_cycles", 64'(n), 64'(9));
    check_output("t5_err_timeout", 64'(err_timeout), 64'(1));
    check_output("t5_no_out_valid", 64'(out_valid), 64'(0));
    fir_enable = 1'b1;
    wait_idle();
    push_sample(16'h000a);
    wait_out_valid(n);
    check_output("t5_next_result", 64'(out_data), 64'(38'h32));
    check_output("t5_frame_last", 64'(out_last), 64'(1));
    wait_idle();

    $display("[TB] reset mid-issue");
    fir_enable = 1'b0;
    push_sample(16'h000b);
    push_sample(16'h000c);
    check_output("t6_in_flight", 64'(fir_in_valid), 64'(1));
    check_output("t6_fir_in", 64'(fir_in), 64'(16'h000b));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("t6_fir_in_valid", 64'(fir_in_valid), 64'(0));
    check_output("t6_in_ready", 64'(in_ready), 64'(1));
    check_output("t6_busy", 64'(busy), 64'(0));
    check_output("t6_err_cleared", 64'(err_timeout), 64'(0));
    fir_enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("t6_fifo_empty", 64'(fir_in_valid | busy), 64'(0));

    $display("[TB] frame tagging");
    for (int i = 0; i < 7; i++) push_sample(IN_W'(20 + i));
    wait_idle();
    check_output("t4_result_count", 64'(nres), 64'(7));
    check_output("t4_last_pattern", 64'(lastv[6:0]), 64'(7'b0100100));

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
